// File: rtl/dac_stim_sequencer.sv
// Sample-driven stimulation sequencer: counts consecutive advancing samples,
// fires a one-cycle trigger at seq_length, then holds off for refract_len samples.
module dac_stim_sequencer #(
  parameter int CNT_W      = 32,
  parameter int STIM_CNT_W = 16
) (
  input  logic                  dataclk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  sample_strobe,
  input  logic                  dac_advance,
  input  logic [CNT_W-1:0]      seq_length,
  input  logic [CNT_W-1:0]      refract_len,
  input  logic                  clear_count,
  output logic [CNT_W-1:0]      state_counter,
  output logic                  stim_trigger,
  output logic                  in_refractory,
  output logic                  busy,
  output logic [STIM_CNT_W-1:0] stim_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TRIG, S_REFR} state_t;

  state_t           state;
  logic [CNT_W-1:0] seq_len_q;
  logic [CNT_W-1:0] refr_len_q;
  logic [CNT_W-1:0] refr_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   seq_eff;
  logic [CNT_W-1:0] refr_inc;

  // One extra bit so the completion compare cannot be fooled by a wrap.
  assign cnt_inc  = {1'b0, state_counter} + (CNT_W+1)'(1);
  assign seq_eff  = (seq_len_q == '0) ? (CNT_W+1)'(1) : {1'b0, seq_len_q};
  assign refr_inc = refr_cnt + CNT_W'(1);

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      state_counter <= '0;
      refr_cnt      <= '0;
      seq_len_q     <= '0;
      refr_len_q    <= '0;
    end else if (!arm) begin
      state         <= S_IDLE;
      state_counter <= '0;
      refr_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_RUN;
          seq_len_q     <= seq_length;
          refr_len_q    <= refract_len;
          state_counter <= '0;
          refr_cnt      <= '0;
        end
        S_RUN: begin
          if (sample_strobe) begin
            if (!dac_advance) begin
              state_counter <= '0;
            end else if (cnt_inc >= seq_eff) begin
              state_counter <= '0;
              state         <= S_TRIG;
            end else begin
              state_counter <= cnt_inc[CNT_W-1:0];
            end
          end
        end
        S_TRIG: begin
          refr_cnt <= '0;
          state    <= (refr_len_q != '0) ? S_REFR : S_RUN;
        end
        S_REFR: begin
          state_counter <= '0;
          if (sample_strobe) begin
            if (refr_inc == refr_len_q) begin
              state    <= S_RUN;
              refr_cnt <= '0;
            end else begin
              refr_cnt <= refr_inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A trigger already in flight is counted even if arm drops that cycle.
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n)
      stim_count <= '0;
    else if (clear_count)
      stim_count <= '0;
    else if (state == S_TRIG && stim_count != '1)
      stim_count <= stim_count + STIM_CNT_W'(1);
  end

  assign stim_trigger  = (state == S_TRIG);
  assign in_refractory = (state == S_REFR);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_dac_stim_sequencer.sv
// Directed vector bench for dac_stim_sequencer; a 4-bit-counter instance
// shares the stimulus to exercise stim_count saturation in few cycles.
module tb_dac_stim_sequencer;

  logic        dataclk = 1'b0;
  logic        reset_n = 1'b1;
  logic        arm = 1'b0, sample_strobe = 1'b0, dac_advance = 1'b0, clear_count = 1'b0;
  logic [31:0] seq_length = '0, refract_len = '0;
  logic [31:0] state_counter, sat_sc;
  logic        stim_trigger, in_refractory, busy;
  logic        sat_trig, sat_refr, sat_busy;
  logic [15:0] stim_count;
  logic [3:0]  sat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 dataclk = ~dataclk;

  dac_stim_sequencer u_dut (
    .dataclk(dataclk), .reset_n(reset_n), .arm(arm), .sample_strobe(sample_strobe),
    .dac_advance(dac_advance), .seq_length(seq_length), .refract_len(refract_len),
    .clear_count(clear_count), .state_counter(state_counter), .stim_trigger(stim_trigger),
    .in_refractory(in_refractory), .busy(busy), .stim_count(stim_count)
  );

  dac_stim_sequencer #(.CNT_W(32), .STIM_CNT_W(4)) u_sat (
    .dataclk(dataclk), .reset_n(reset_n), .arm(arm), .sample_strobe(sample_strobe),
    .dac_advance(dac_advance), .seq_length(seq_length), .refract_len(refract_len),
    .clear_count(clear_count), .state_counter(sat_sc), .stim_trigger(sat_trig),
    .in_refractory(sat_refr), .busy(sat_busy), .stim_count(sat_cnt)
  );

  typedef struct {
    logic        arm, stb, adv, clr;
    logic [31:0] seq, rl;
    logic [31:0] e_sc;
    logic        e_trig, e_refr, e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic a, s, d, c, input int sq, r, sc,
                     input logic t, rf, b, input int cnt);
    vec_t v;
    v.arm = a; v.stb = s; v.adv = d; v.clr = c;
    v.seq = sq; v.rl = r; v.e_sc = sc;
    v.e_trig = t; v.e_refr = rf; v.e_busy = b; v.e_cnt = 16'(cnt);
    tbl.push_back(v);
  endtask

  task automatic tick;
    @(posedge dataclk);
    #1;
  endtask

  initial begin
    //   arm stb adv clr seq rl  sc trig refr busy cnt
    add(1, 0, 0, 0, 4, 0,  0, 0, 0, 1, 0);  // 0 arm -> RUN
    add(1, 1, 1, 0, 4, 0,  1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 4, 0,  2, 0, 0, 1, 0);
    add(1, 1, 1, 0, 4, 0,  3, 0, 0, 1, 0);
    add(1, 1, 1, 0, 4, 0,  0, 1, 0, 1, 0);  // 4 completing strobe
    add(1, 0, 0, 0, 4, 0,  0, 0, 0, 1, 1);  // pulse gone, counted
    add(1, 1, 1, 0, 4, 0,  1, 0, 0, 1, 1);  // 5th strobe
    add(1, 1, 0, 0, 4, 0,  0, 0, 0, 1, 1);  // 7 advance pattern 1,1,0,1
    add(1, 1, 1, 0, 4, 0,  1, 0, 0, 1, 1);
    add(1, 1, 1, 0, 4, 0,  2, 0, 0, 1, 1);
    add(1, 1, 0, 0, 4, 0,  0, 0, 0, 1, 1);
    add(1, 1, 1, 0, 4, 0,  1, 0, 0, 1, 1);
    add(1, 0, 1, 0, 4, 0,  1, 0, 0, 1, 1);  // 12 no strobe holds
    add(0, 0, 0, 0, 2, 3,  0, 0, 0, 0, 1);  // 13 disarm
    add(1, 0, 0, 0, 2, 3,  0, 0, 0, 1, 1);  // 14 seq=2 refr=3
    add(1, 1, 1, 0, 2, 3,  1, 0, 0, 1, 1);
    add(1, 1, 1, 0, 2, 3,  0, 1, 0, 1, 1);  // 16 trigger
    add(1, 1, 1, 0, 2, 3,  0, 0, 1, 1, 2);  // 17 strobe in TRIGGER ignored
    add(1, 1, 1, 0, 2, 3,  0, 0, 1, 1, 2);
    add(1, 1, 1, 0, 2, 3,  0, 0, 1, 1, 2);
    add(1, 1, 1, 0, 2, 3,  0, 0, 0, 1, 2);  // 20 3rd refractory strobe -> RUN
    add(1, 1, 1, 0, 2, 3,  1, 0, 0, 1, 2);
    add(1, 1, 1, 0, 2, 3,  0, 1, 0, 1, 2);  // 22 second trigger
    add(1, 0, 0, 0, 2, 3,  0, 0, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);  // 24 arm dropped in REFRACT
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 3);  // 25 seq=0
    add(1, 1, 1, 0, 0, 0,  0, 1, 0, 1, 3);  // 26 first advancing strobe triggers
    add(1, 0, 0, 0, 10, 0, 0, 0, 0, 1, 4);  // 27 seq=10 while busy
    add(1, 1, 1, 0, 10, 0, 0, 1, 0, 1, 4);  // 28 still length 1
    add(1, 0, 0, 0, 10, 0, 0, 0, 0, 1, 5);
    add(0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 5);  // 30 re-arm picks up 10
    add(1, 0, 0, 0, 10, 0, 0, 0, 0, 1, 5);
    add(1, 1, 1, 0, 10, 0, 1, 0, 0, 1, 5);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 5);
    add(1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 5);
    add(1, 1, 1, 0, 1, 0,  0, 1, 0, 1, 5);  // 35 trigger
    add(1, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0);  // 36 clear coincides with trigger
    add(1, 1, 1, 0, 1, 0,  0, 1, 0, 1, 0);  // 37 trigger
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1);  // 38 disarm in TRIGGER, pulse counted
    add(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0);  // 39 plain clear

    // Reset asserted asynchronously away from any edge
    #2 reset_n = 1'b0;
    #1;
    chk("reset_sc",   state_counter, 0);
    chk("reset_busy", {stim_trigger, in_refractory, busy}, 0);
    chk("reset_cnt",  stim_count, 0);
    tick; tick;
    reset_n = 1'b1;
    tick;
    chk("idle_busy", busy, 0);

    foreach (tbl[i]) begin
      arm = tbl[i].arm; sample_strobe = tbl[i].stb; dac_advance = tbl[i].adv;
      clear_count = tbl[i].clr; seq_length = tbl[i].seq; refract_len = tbl[i].rl;
      tick;
      chk($sformatf("v%0d_sc", i),   state_counter, tbl[i].e_sc);
      chk($sformatf("v%0d_trig", i), stim_trigger,  tbl[i].e_trig);
      chk($sformatf("v%0d_refr", i), in_refractory, tbl[i].e_refr);
      chk($sformatf("v%0d_busy", i), busy,          tbl[i].e_busy);
      chk($sformatf("v%0d_cnt", i),  stim_count,    tbl[i].e_cnt);
    end
    sample_strobe = 0; dac_advance = 0; clear_count = 0;

    // Saturation: 20 triggers on back-to-back strobes; 4-bit counter pins at 0xF
    arm = 1; seq_length = 1; refract_len = 0;
    tick;
    sample_strobe = 1; dac_advance = 1;
    for (int c = 0; c < 40; c++) tick;
    sample_strobe = 0; dac_advance = 0;
    chk("sat_main_cnt", stim_count, 20);
    chk("sat_small_cnt", sat_cnt, 4'hF);
    tick;
    chk("sat_small_hold", sat_cnt, 4'hF);

    // Asynchronous reset mid-RUN at state_counter = 5
    arm = 0; tick;
    arm = 1; seq_length = 10; tick;
    sample_strobe = 1; dac_advance = 1;
    for (int c = 0; c < 5; c++) tick;
    sample_strobe = 0;
    chk("pre_reset_sc", state_counter, 5);
    #3 reset_n = 1'b0;
    #1;
    chk("midrun_reset_sc",   state_counter, 0);
    chk("midrun_reset_outs", {stim_trigger, in_refractory, busy}, 0);
    chk("midrun_reset_cnt",  stim_count, 0);
    arm = 0;
    tick;
    reset_n = 1'b1;
    tick;
    chk("post_reset_idle", {busy, state_counter}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_stim_sequencer.md
# dac_stim_sequencer

Sequencing controller for the DAC threshold/window datapath: generates the 32-bit state counter the window comparators consume, advances it on each sample while the datapath's advance condition holds, and issues a one-cycle stimulation trigger when the sequence completes. It then enforces a programmable refractory period before re-arming. It sits between the per-sample data strobe of the amplifier pipeline and the stimulation trigger logic, and operates in the `dataclk` domain.

## Interface
- CNT_W, 32, width of state counter, sequence length and refractory length
- STIM_CNT_W, 16, width of saturating trigger counter
- dataclk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  level; 1 = sequencer enabled, 0 = forced to IDLE
- sample_strobe  in  1  one-cycle pulse per new sample; gates all counting
- dac_advance  in  1  datapath condition (windows/thresholds satisfied, at least one DAC enabled)
- seq_length  in  CNT_W  samples of continuous advance required to trigger; 0 treated as 1
- refract_len  in  CNT_W  samples to hold off after a trigger; 0 = no refractory
- clear_count  in  1  synchronous clear of stim_count
- state_counter  out  CNT_W  registered counter driven to the window comparators
- stim_trigger  out  1  one-cycle trigger pulse
- in_refractory  out  1  high while in REFRACT
- busy  out  1  high in any state except IDLE
- stim_count  out  STIM_CNT_W  number of triggers issued, saturating

## Operation
- States: IDLE, RUN, TRIGGER, REFRACT; encoding is free; all outputs registered or decoded from registered state.
- Config latch: seq_length and refract_len captured into internal registers on the IDLE->RUN transition; changes while busy have no effect until the next re-arm.
- IDLE: state_counter = 0. arm = 1 -> RUN next cycle.
- RUN, on sample_strobe:
  - dac_advance = 0 -> state_counter <= 0, remain RUN.
  - dac_advance = 1 and state_counter + 1 >= latched seq_length (0 treated as 1) -> state_counter <= 0, go TRIGGER.
  - otherwise state_counter <= state_counter + 1.
  - No sample_strobe -> hold counter and state.
- TRIGGER: lasts exactly one dataclk cycle; stim_trigger = 1; stim_count increments unless at all-ones. Next: REFRACT if latched refract_len != 0, else RUN. Any sample_strobe in this cycle is ignored.
- REFRACT: state_counter held 0; dac_advance ignored; an internal refractory counter starts at 0 on entry and increments on each sample_strobe; on the strobe where refr_cnt + 1 == latched refract_len -> RUN with refr_cnt cleared.
- arm = 0 has highest priority in every state: next cycle IDLE, state_counter and refr_cnt cleared. A TRIGGER cycle already entered still emits its pulse.
- clear_count zeroes stim_count next cycle; if it coincides with a TRIGGER cycle, clear wins and the result is 0.
- The counter never wraps, because reaching seq_length always returns it to 0.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, state_counter = 0, stim_trigger = 0, in_refractory = 0, busy = 0, stim_count = 0, latched config = 0.
- arm rising at edge t -> busy = 1 from t+1.
- A completing sample_strobe at edge t -> stim_trigger high for the cycle t to t+1 -> in_refractory or RUN from t+1.
- dac_advance is sampled only in the cycle sample_strobe is high. Latency from strobe to state_counter update is 1 cycle.
- Back-to-back sample_strobe on consecutive cycles must be supported, with one count per strobe.

## Test plan
- Reset mid-RUN with state_counter = 5 -> all outputs 0 immediately, without waiting for a clock edge; IDLE after release.
- arm = 1, seq_length = 4, refract_len = 0, advance = 1 on 4 strobes -> state_counter 1,2,3; the 4th strobe gives stim_trigger for exactly 1 cycle and stim_count = 1; a 5th strobe gives state_counter = 1.
- seq_length = 4, advance = 1,1,0,1 -> state_counter 1,2,0,1; no trigger.
- seq_length = 2, refract_len = 3 -> trigger, then in_refractory for exactly 3 strobes with advance = 1 ignored; the next 2 strobes give the second trigger.
- seq_length = 0 -> trigger on the first advancing strobe. seq_length changed to 10 while busy -> no effect until arm is toggled.
- stim_count preloaded by 65535 triggers -> stays 0xFFFF on the next trigger. clear_count coinciding with a trigger -> 0. arm dropped in REFRACT -> IDLE next cycle, counters 0.
